// File: rtl/nmr_alu.sv
// N-way modular-redundant ALU: replicated AND/OR/SUM/SLT datapaths, per-bit majority vote
// over the active replicas, and sticky retirement of replicas that keep disagreeing.
module nmr_alu #(
  parameter int WIDTH        = 32,
  parameter int N            = 5,
  parameter int FAULT_THRESH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alucont,
  input  logic             clr_faults,
  input  logic             inj_en,
  input  logic [2:0]       inj_sel,
  input  logic [WIDTH-1:0] inj_mask,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             out_valid,
  output logic             tie,
  output logic [N-1:0]     fault_mask,
  output logic [2:0]       n_active
);

  localparam int VW = WIDTH + 1;

  logic [N-1:0][VW-1:0] rep_vec;

  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             tie_q, tie_d;
  logic             out_valid_q, out_valid_d;
  logic [N-1:0]     fault_mask_q, fault_mask_d;
  logic [N-1:0][3:0] cnt_q, cnt_d;

  logic [VW-1:0]    voted;
  logic             tie_any;
  logic [VW-1:0]    low_vec;
  logic [N-1:0]     low_oh;
  logic [2:0]       fault_cnt;

  for (genvar i = 0; i < N; i++) begin : g_rep
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] res;

    assign b_eff = alucont[2] ? ~b : b;
    assign sum   = a + b_eff + {{(WIDTH-1){1'b0}}, alucont[2]};
    assign raw   = (alucont[1:0] == 2'b00) ? (a & b_eff) :
                   (alucont[1:0] == 2'b01) ? (a | b_eff) :
                   (alucont[1:0] == 2'b10) ? sum :
                   {{(WIDTH-1){1'b0}}, sum[WIDTH-1]};
    // Index compare against i alone means inj_sel >= N never hits any replica.
    assign res   = raw ^ ((inj_en && inj_sel == 3'(i)) ? inj_mask : '0);
    assign rep_vec[i] = {(res == '0), res};
  end

  always_comb begin
    fault_cnt = '0;
    for (int i = 0; i < N; i++) begin
      if (fault_mask_q[i]) fault_cnt = fault_cnt + 3'd1;
    end
    n_active = 3'(N) - fault_cnt;
  end

  always_comb begin
    low_vec = rep_vec[0];
    low_oh  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!fault_mask_q[i]) begin
        low_vec = rep_vec[i];
        low_oh  = '0;
        low_oh[i] = 1'b1;
      end
    end
  end

  // Exact ties fall back to the lowest-index active replica, so that replica always agrees.
  always_comb begin
    logic [2:0] ones;
    logic [3:0] twice;
    voted   = '0;
    tie_any = 1'b0;
    ones    = '0;
    twice   = '0;
    for (int j = 0; j < VW; j++) begin
      ones = '0;
      for (int i = 0; i < N; i++) begin
        if (!fault_mask_q[i] && rep_vec[i][j]) ones = ones + 3'd1;
      end
      twice = {ones, 1'b0};
      if (twice > {1'b0, n_active}) begin
        voted[j] = 1'b1;
      end else if (twice == {1'b0, n_active}) begin
        voted[j] = low_vec[j];
        tie_any  = 1'b1;
      end else begin
        voted[j] = 1'b0;
      end
    end
  end

  always_comb begin
    result_d    = result_q;
    zero_d      = zero_q;
    tie_d       = tie_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      result_d = voted[WIDTH-1:0];
      zero_d   = voted[WIDTH];
      tie_d    = tie_any;
    end
  end

  always_comb begin
    fault_mask_d = fault_mask_q;
    cnt_d        = cnt_q;
    if (clr_faults) begin
      fault_mask_d = '0;
      cnt_d        = '0;
    end else if (in_valid) begin
      for (int i = 0; i < N; i++) begin
        if (!fault_mask_q[i]) begin
          if (rep_vec[i] != voted) begin
            cnt_d[i] = cnt_q[i] + 4'd1;
            if (cnt_q[i] + 4'd1 >= 4'(FAULT_THRESH)) fault_mask_d[i] = 1'b1;
          end else begin
            cnt_d[i] = '0;
          end
        end
      end
      // Never retire every replica at once; the lowest active one survives.
      if (&fault_mask_d) fault_mask_d = fault_mask_d & ~low_oh;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q     <= '0;
      zero_q       <= 1'b0;
      tie_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      fault_mask_q <= '0;
      cnt_q        <= '0;
    end else begin
      result_q     <= result_d;
      zero_q       <= zero_d;
      tie_q        <= tie_d;
      out_valid_q  <= out_valid_d;
      fault_mask_q <= fault_mask_d;
      cnt_q        <= cnt_d;
    end
  end

  assign result     = result_q;
  assign zero       = zero_q;
  assign tie        = tie_q;
  assign out_valid  = out_valid_q;
  assign fault_mask = fault_mask_q;

endmodule

// File: tb/tb_nmr_alu.sv
// Scoreboard bench for nmr_alu (N=5, WIDTH=32, FAULT_THRESH=2): expected vote results are
// queued when an operation is issued and popped when the output registers.
module tb_nmr_alu;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  alucont;
  logic        clr_faults;
  logic        inj_en;
  logic [2:0]  inj_sel;
  logic [31:0] inj_mask;
  logic [31:0] result;
  logic        zero;
  logic        out_valid;
  logic        tie;
  logic [4:0]  fault_mask;
  logic [2:0]  n_active;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        t;
  } exp_t;

  exp_t expQ[$];
  int   errCount   = 0;
  int   checkCount = 0;

  nmr_alu #(.WIDTH(32), .N(5), .FAULT_THRESH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .alucont   (alucont),
    .clr_faults(clr_faults),
    .inj_en    (inj_en),
    .inj_sel   (inj_sel),
    .inj_mask  (inj_mask),
    .result    (result),
    .zero      (zero),
    .out_valid (out_valid),
    .tie       (tie),
    .fault_mask(fault_mask),
    .n_active  (n_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] aluModel(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op);
    logic [31:0] yy;
    logic [31:0] s;
    yy = op[2] ? ~y : y;
    s  = op[2] ? (x - y) : (x + y);
    case (op[1:0])
      2'b00:   return x & yy;
      2'b01:   return x | yy;
      2'b10:   return s;
      default: return {31'd0, s[31]};
    endcase
  endfunction

  // Issues one valid operation at the falling edge and returns just after the capturing edge.
  task automatic applyStimulus(input logic [31:0] va, input logic [31:0] vb, input logic [2:0] op,
                               input logic ie, input logic [2:0] isel, input logic clr,
                               input logic expTie);
    exp_t e;
    logic [31:0] r;
    @(negedge clk);
    a          = va;
    b          = vb;
    alucont    = op;
    inj_en     = ie;
    inj_sel    = isel;
    clr_faults = clr;
    in_valid   = 1'b1;
    r     = aluModel(va, vb, op);
    e.res = r;
    e.z   = (r == 32'd0);
    e.t   = expTie;
    expQ.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic clr);
    @(negedge clk);
    in_valid   = 1'b0;
    inj_en     = 1'b0;
    clr_faults = clr;
    @(posedge clk);
    #2;
    clr_faults = 1'b0;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("out_valid", {63'd0, out_valid}, 64'd1);
      checkOutput("result", {32'd0, result}, {32'd0, e.res});
      checkOutput("zero", {63'd0, zero}, {63'd0, e.z});
      checkOutput("tie", {63'd0, tie}, {63'd0, e.t});
    end else begin
      checkOutput("idle_out_valid", {63'd0, out_valid}, 64'd0);
    end
  end

  initial begin
    reset      = 1'b0;
    in_valid   = 1'b0;
    a          = '0;
    b          = '0;
    alucont    = '0;
    clr_faults = 1'b0;
    inj_en     = 1'b0;
    inj_sel    = '0;
    inj_mask   = 32'd1;

    // Operands presented while reset is held must not produce output.
    @(negedge clk);
    a = 32'd5; b = 32'd7; alucont = 3'b010; in_valid = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    checkOutput("rst_result", {32'd0, result}, 64'd0);
    checkOutput("rst_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_mask", {59'd0, fault_mask}, 64'd0);
    checkOutput("rst_nactive", {61'd0, n_active}, 64'd5);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk); #2;

    applyStimulus(32'd5, 32'd7, 3'b010, 1'b0, 3'd0, 1'b0, 1'b0);
    idle(1'b0);
    checkOutput("hold_result", {32'd0, result}, 64'd12);

    applyStimulus(32'd3, 32'd5, 3'b110, 1'b0, 3'd0, 1'b0, 1'b0);
    applyStimulus(32'd3, 32'd5, 3'b111, 1'b0, 3'd0, 1'b0, 1'b0);
    applyStimulus(32'd9, 32'd9, 3'b110, 1'b0, 3'd0, 1'b0, 1'b0);
    applyStimulus(32'h0000F0F0, 32'h0000FF00, 3'b000, 1'b0, 3'd0, 1'b0, 1'b0);
    applyStimulus(32'h0000F0F0, 32'h0000FF00, 3'b001, 1'b0, 3'd0, 1'b0, 1'b0);
    applyStimulus(32'h0000F0F0, 32'h0000FF00, 3'b100, 1'b0, 3'd0, 1'b0, 1'b0);
    applyStimulus(32'd3, 32'd5, 3'b011, 1'b0, 3'd0, 1'b0, 1'b0);
    applyStimulus(32'hFFFFFFFF, 32'd1, 3'b010, 1'b0, 3'd0, 1'b0, 1'b0);
    idle(1'b0);

    // Two consecutive injections retire replica 2.
    applyStimulus(32'd5, 32'd7, 3'b010, 1'b1, 3'd2, 1'b0, 1'b0);
    checkOutput("inj2_mask1", {59'd0, fault_mask}, 64'h00);
    applyStimulus(32'd5, 32'd7, 3'b010, 1'b1, 3'd2, 1'b0, 1'b0);
    checkOutput("inj2_mask2", {59'd0, fault_mask}, 64'h04);
    checkOutput("inj2_nactive", {61'd0, n_active}, 64'd4);
    applyStimulus(32'd5, 32'd7, 3'b010, 1'b1, 3'd5, 1'b0, 1'b0);
    applyStimulus(32'd5, 32'd7, 3'b010, 1'b1, 3'd5, 1'b0, 1'b0);
    checkOutput("inj5_mask", {59'd0, fault_mask}, 64'h04);
    checkOutput("inj5_nactive", {61'd0, n_active}, 64'd4);

    applyStimulus(32'd5, 32'd7, 3'b010, 1'b1, 3'd1, 1'b0, 1'b0);
    applyStimulus(32'd5, 32'd7, 3'b010, 1'b1, 3'd1, 1'b0, 1'b0);
    applyStimulus(32'd5, 32'd7, 3'b010, 1'b1, 3'd3, 1'b0, 1'b0);
    applyStimulus(32'd5, 32'd7, 3'b010, 1'b1, 3'd3, 1'b0, 1'b0);
    checkOutput("ret13_mask", {59'd0, fault_mask}, 64'h0E);
    checkOutput("ret13_nactive", {61'd0, n_active}, 64'd2);

    // Only replicas 0 and 4 remain: a flip on 4 is an exact tie resolved by replica 0.
    applyStimulus(32'd5, 32'd7, 3'b010, 1'b1, 3'd4, 1'b0, 1'b1);
    applyStimulus(32'd5, 32'd7, 3'b010, 1'b1, 3'd4, 1'b0, 1'b1);
    checkOutput("ret4_mask", {59'd0, fault_mask}, 64'h1E);
    checkOutput("ret4_nactive", {61'd0, n_active}, 64'd1);
    applyStimulus(32'd20, 32'd22, 3'b010, 1'b0, 3'd0, 1'b0, 1'b0);
    idle(1'b0);

    idle(1'b1);
    checkOutput("clr_mask", {59'd0, fault_mask}, 64'h00);
    checkOutput("clr_nactive", {61'd0, n_active}, 64'd5);

    // Clear wins over a simultaneous mismatch, so one more mismatch must not retire replica 0.
    applyStimulus(32'd2, 32'd2, 3'b010, 1'b1, 3'd0, 1'b1, 1'b0);
    checkOutput("clrop_mask", {59'd0, fault_mask}, 64'h00);
    checkOutput("clrop_nactive", {61'd0, n_active}, 64'd5);
    applyStimulus(32'd2, 32'd2, 3'b010, 1'b1, 3'd0, 1'b0, 1'b0);
    checkOutput("clrcnt_mask", {59'd0, fault_mask}, 64'h00);
    idle(1'b0);

    // Reset asserted mid-operation discards it.
    @(negedge clk);
    a = 32'd1; b = 32'd1; alucont = 3'b010; in_valid = 1'b1;
    #1 reset = 1'b0;
    @(posedge clk); #2;
    checkOutput("midrst_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("midrst_result", {32'd0, result}, 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk); #2;
    applyStimulus(32'd1, 32'd1, 3'b010, 1'b0, 3'd0, 1'b0, 1'b0);
    idle(1'b0);

    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
